// File: rtl/muldiv_seq_unit.sv
// Sequential MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One radix-2 step per cycle; the result is sign-corrected and written to HI/LO in FIX.
module muldiv_seq_unit #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   funct,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         flush,
    input  logic         wr_hi,
    input  logic         wr_lo,
    input  logic [W-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0]   ZERO_W   = {W{1'b0}};
    localparam logic [W-1:0]   ONE_W    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0] ONE_2W   = {{(2*W-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  CNT_INIT = CW'(W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic neg);
        if (neg) cond_neg = ~v + ONE_W;
        else     cond_neg = v;
    endfunction

    function automatic logic [2*W-1:0] cond_neg2(input logic [2*W-1:0] v, input logic neg);
        if (neg) cond_neg2 = ~v + ONE_2W;
        else     cond_neg2 = v;
    endfunction

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r;
    logic            div_r, neg_r, rneg_r;
    logic [W-1:0]    op_r;
    logic [2*W-1:0]  acc_r;
    logic            busy_r, done_r;
    logic [W-1:0]    hi_r, lo_r;

    logic            start_ok_s, cancel_s, fix_ok_s;
    logic            a_neg_s, b_neg_s, b_zero_s;
    logic [W-1:0]    mag_a_s, mag_b_s;
    logic [W:0]      mul_sum_s, div_shift_s, div_trial_s;
    logic [2*W-1:0]  mul_next_s, div_next_s, prod_s;
    logic [W-1:0]    quot_s, rem_s, res_hi_s, res_lo_s;

    assign start_ok_s = start & ~flush & ~wr_hi & ~wr_lo;
    assign cancel_s   = flush | wr_hi | wr_lo;
    assign fix_ok_s   = (state_r == ST_FIX) & ~flush;

    // Signed ops work on magnitudes; funct[0]=0 marks the signed variants.
    assign a_neg_s  = ~funct[0] & a[W-1];
    assign b_neg_s  = ~funct[0] & b[W-1];
    assign b_zero_s = (b == ZERO_W);
    assign mag_a_s  = cond_neg(a, a_neg_s);
    assign mag_b_s  = cond_neg(b, b_neg_s);

    // One shift-add multiply step and one restoring divide step on acc_r.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*W-1:W]} + {1'b0, (acc_r[0] ? op_r : ZERO_W)};
        mul_next_s  = {mul_sum_s, acc_r[W-1:1]};
        div_shift_s = {acc_r[2*W-1:W], acc_r[W-1]};
        div_trial_s = div_shift_s - {1'b0, op_r};
        if (div_trial_s[W]) div_next_s = {div_shift_s[W-1:0], acc_r[W-2:0], 1'b0};
        else                div_next_s = {div_trial_s[W-1:0], acc_r[W-2:0], 1'b1};
    end

    // Sign correction of the finished result; a zero divisor leaves the quotient all ones.
    always_comb begin
        prod_s = cond_neg2(acc_r, neg_r);
        quot_s = cond_neg(acc_r[W-1:0], neg_r);
        rem_s  = cond_neg(acc_r[2*W-1:W], rneg_r);
        if (div_r) begin
            res_hi_s = rem_s;
            res_lo_s = quot_s;
        end else begin
            res_hi_s = prod_s[2*W-1:W];
            res_lo_s = prod_s[W-1:0];
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: if (start_ok_s) state_s = ST_RUN; else state_s = ST_IDLE;
            ST_RUN: begin
                if (cancel_s)                state_s = ST_IDLE;
                else if (cnt_r == CNT_ONE)   state_s = ST_FIX;
                else                         state_s = ST_RUN;
            end
            ST_FIX:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= state_s;
    end

    // Operand latch and per-cycle iteration.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r  <= {CW{1'b0}};
            div_r  <= 1'b0;
            neg_r  <= 1'b0;
            rneg_r <= 1'b0;
            op_r   <= ZERO_W;
            acc_r  <= {(2*W){1'b0}};
        end else if ((state_r == ST_IDLE) && start_ok_s) begin
            cnt_r  <= CNT_INIT;
            div_r  <= funct[1];
            neg_r  <= (a_neg_s ^ b_neg_s) & ~(funct[1] & b_zero_s);
            rneg_r <= funct[1] & a_neg_s;
            op_r   <= funct[1] ? mag_b_s : mag_a_s;
            acc_r  <= {ZERO_W, (funct[1] ? mag_a_s : mag_b_s)};
        end else if (state_r == ST_RUN) begin
            cnt_r  <= cnt_r - CNT_ONE;
            acc_r  <= div_r ? div_next_s : mul_next_s;
        end
    end

    // Architectural HI/LO; a direct write wins over the result of the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r   <= ZERO_W;
            lo_r   <= ZERO_W;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            if (wr_hi)         hi_r <= wdata;
            else if (fix_ok_s) hi_r <= res_hi_s;
            if (wr_lo)         lo_r <= wdata;
            else if (fix_ok_s) lo_r <= res_lo_s;
            busy_r <= (state_s != ST_IDLE);
            done_r <= fix_ok_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Randomised and directed bench for muldiv_seq_unit (W=32) against a plain-arithmetic model.
module tb_muldiv_seq_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset, start, flush, wr_hi, wr_lo;
    logic [1:0]    funct;
    logic [W-1:0]  a, b, wdata;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    int n_checks = 0;
    int n_pass   = 0;
    int done_seen = 0;

    muldiv_seq_unit #(.W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .funct(funct), .a(a), .b(b),
        .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (done) done_seen++;
    endtask

    // Reference: 64-bit arithmetic; SV '/' and '%' truncate toward zero with dividend-signed remainder.
    task automatic model(input logic [1:0] f, input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] eh, output logic [31:0] el);
        longint sa, sb, q, r, p;
        logic [63:0] up;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        case (f)
            2'd0: begin p = sa * sb; up = p; eh = up[63:32]; el = up[31:0]; end
            2'd1: begin up = {32'd0, av} * {32'd0, bv}; eh = up[63:32]; el = up[31:0]; end
            2'd2: begin
                if (bv == 32'd0) begin eh = av; el = 32'hFFFF_FFFF; end
                else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin eh = 32'd0; el = 32'h8000_0000; end
                else begin q = sa / sb; r = sa % sb; el = 32'(q); eh = 32'(r); end
            end
            default: begin
                if (bv == 32'd0) begin eh = av; el = 32'hFFFF_FFFF; end
                else begin el = av / bv; eh = av % bv; end
            end
        endcase
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: pick = 32'd0;
            1: pick = 32'hFFFF_FFFF;
            2: pick = 32'h8000_0000;
            3: pick = 32'($urandom_range(0, 15));
            default: pick = $urandom;
        endcase
    endfunction

    // Starts an op in the current cycle (cycle 0) and returns in its done cycle.
    // inj_kind 1: stray start at inj_cyc; 2: direct LO write of 0x55 at inj_cyc.
    task automatic run_op(input logic [1:0] f, input logic [31:0] av, input logic [31:0] bv,
                          input int inj_cyc, input int inj_kind, input string tag);
        logic [31:0] eh, el;
        int cyc;
        bit busy_ok;
        model(f, av, bv, eh, el);
        if (inj_kind == 2) el = 32'h0000_0055;
        funct = f; a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (!done && cyc < 60) begin
            if (!busy) busy_ok = 1'b0;
            if (cyc == inj_cyc && inj_kind == 1) begin
                start = 1'b1; funct = 2'd3; a = $urandom; b = $urandom;
            end
            if (cyc == inj_cyc && inj_kind == 2) begin
                wr_lo = 1'b1; wdata = 32'h0000_0055;
            end
            tick();
            start = 1'b0;
            wr_lo = 1'b0;
            cyc++;
        end
        check_eq({tag, "/done_cycle"}, 64'(cyc), 64'(W + 2));
        check_eq({tag, "/busy_run"}, 64'(busy_ok), 64'd1);
        check_eq({tag, "/busy_done"}, 64'(busy), 64'd0);
        check_eq({tag, "/hi"}, 64'(hi), 64'(eh));
        check_eq({tag, "/lo"}, 64'(lo), 64'(el));
    endtask

    task automatic preload(input logic [31:0] hv, input logic [31:0] lv);
        wr_hi = 1'b1; wdata = hv; tick(); wr_hi = 1'b0;
        wr_lo = 1'b1; wdata = lv; tick(); wr_lo = 1'b0;
    endtask

    initial begin
        int d0;
        reset = 1'b1; start = 1'b0; flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        funct = 2'd0; a = 32'd0; b = 32'd0; wdata = 32'd0;
        tick(); tick();
        check_eq("reset/busy", 64'(busy), 64'd0);
        check_eq("reset/done", 64'(done), 64'd0);
        check_eq("reset/hi", 64'(hi), 64'd0);
        check_eq("reset/lo", 64'(lo), 64'd0);
        reset = 1'b0;
        tick();

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "multu_max");
        tick();
        check_eq("done_pulse", 64'(done), 64'd0);
        run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 0, 0, "mult_neg");
        run_op(2'd0, 32'd0, 32'h7FFF_FFFF, 0, 0, "mult_b2b");
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, "div_neg");
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div_ovf");
        run_op(2'd3, 32'd100, 32'd0, 0, 0, "divu_zero");
        run_op(2'd2, 32'hFFFF_FF9C, 32'd0, 0, 0, "div_zero_neg");

        // Flush mid-run, then restart in the following cycle.
        preload(32'h11, 32'h22);
        d0 = done_seen;
        funct = 2'd1; a = 32'd7; b = 32'd9; start = 1'b1;
        tick(); start = 1'b0;
        repeat (9) tick();
        flush = 1'b1; tick(); flush = 1'b0;
        check_eq("flush/busy", 64'(busy), 64'd0);
        check_eq("flush/hi", 64'(hi), 64'h11);
        check_eq("flush/lo", 64'(lo), 64'h22);
        check_eq("flush/no_done", 64'(done_seen - d0), 64'd0);
        run_op(2'd1, 32'd7, 32'd9, 0, 0, "after_flush");

        // Reset in the middle of an operation.
        d0 = done_seen;
        funct = 2'd1; a = 32'd3; b = 32'd3; start = 1'b1;
        tick(); start = 1'b0;
        repeat (14) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check_eq("midreset/busy", 64'(busy), 64'd0);
        check_eq("midreset/hi", 64'(hi), 64'd0);
        check_eq("midreset/lo", 64'(lo), 64'd0);
        repeat (W + 4) tick();
        check_eq("midreset/no_done", 64'(done_seen - d0), 64'd0);

        // Direct HI write in RUN cancels the operation.
        preload(32'h0, 32'h22);
        d0 = done_seen;
        funct = 2'd1; a = 32'd3; b = 32'd4; start = 1'b1;
        tick(); start = 1'b0;
        repeat (4) tick();
        wr_hi = 1'b1; wdata = 32'hAA; tick(); wr_hi = 1'b0;
        check_eq("wrhi/busy", 64'(busy), 64'd0);
        check_eq("wrhi/hi", 64'(hi), 64'hAA);
        check_eq("wrhi/lo", 64'(lo), 64'h22);
        repeat (W + 4) tick();
        check_eq("wrhi/no_done", 64'(done_seen - d0), 64'd0);
        check_eq("wrhi/lo_hold", 64'(lo), 64'h22);

        // Stray start during RUN is ignored and not queued.
        run_op(2'd1, 32'd1234, 32'd5678, 20, 1, "stray_start");
        tick();
        check_eq("stray_start/not_queued", 64'(busy), 64'd0);

        // Direct LO write in FIX wins over the result; done still pulses.
        run_op(2'd3, 32'd1000, 32'd7, W + 1, 2, "fix_wrlo");

        // In IDLE, flush and direct writes both block a start.
        start = 1'b1; flush = 1'b1; tick(); start = 1'b0; flush = 1'b0;
        check_eq("flush_beats_start", 64'(busy), 64'd0);
        start = 1'b1; wr_hi = 1'b1; wdata = 32'h5A5A; tick(); start = 1'b0; wr_hi = 1'b0;
        check_eq("wr_beats_start/busy", 64'(busy), 64'd0);
        check_eq("wr_beats_start/hi", 64'(hi), 64'h5A5A);

        for (int i = 0; i < 16; i++) begin
            logic [1:0] rf;
            logic [31:0] ra, rb;
            rf = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            run_op(rf, ra, rb, 0, 0, $sformatf("rand%0d_f%0d", i, rf));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_seq_unit.md
# muldiv_seq_unit

Parametrised sequential multiply/divide unit that executes MULT, MULTU, DIV and DIVU for the execute stage. It owns the architectural HI/LO registers. It generalises the single-cycle hi/lo write path to a configurable operand width with a multi-cycle iterative datapath, a busy/done handshake for pipeline stalling, cancellation on flush, and direct MTHI/MTLO writes. Control inputs come straight from the decoded `muldiv_funct`, `write_hi`/`write_lo` and `hilo_src` fields.

## Interface
- `W`, default 32: operand, HI and LO width; legal values are W ≥ 4.
- `clk` in, 1: single clock; all state updates on the rising edge.
- `reset` in, 1: synchronous, active-high.
- `start` in, 1: request to begin an operation; sampled only when `busy`=0.
- `funct` in, 2: `selector` muldiv encoding: MULT=0, MULTU=1, DIV=2, DIVU=3.
- `a` in, W: rs operand (multiplicand or dividend).
- `b` in, W: rt operand (multiplier or divisor).
- `flush` in, 1: cancels any in-flight operation.
- `wr_hi` in, 1: MTHI, HI ← `wdata`.
- `wr_lo` in, 1: MTLO, LO ← `wdata`.
- `wdata` in, W: rs value for MTHI/MTLO.
- `busy` out, 1: operation in flight; the pipeline stalls on MFHI/MFLO and on a new muldiv while this is high.
- `done` out, 1: one-cycle pulse; `hi`/`lo` hold the new result in this cycle.
- `hi` out, W: HI register.
- `lo` out, W: LO register.

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: W iterations, 1 per cycle, driven by a down-counter of width $clog2(W+1).
  - FIX: sign correction and HI/LO write.
- IDLE→RUN when `start`=1 and `flush`=0 and `wr_hi`=`wr_lo`=0. On this transition:
  - latch `funct`;
  - latch |a| and |b| for signed ops, or raw a and b for unsigned ops;
  - latch the result sign flags.
- RUN→FIX after the W-th iteration. FIX→IDLE unconditionally, with `done`=1 registered into the IDLE cycle.
- Multiply: radix-2 shift-add on magnitudes into a 2W accumulator. In FIX, the product is negated if the signs differ (MULT only). HI = upper W bits, LO = lower W bits.
- Divide: radix-2 restoring divide on magnitudes; one quotient bit per cycle, MSB first.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
- Divide by zero (`b`=0, DIV or DIVU): LO = all ones, HI = `a` unmodified. Latency is unchanged.
- Signed overflow (DIV of most-negative by −1): LO = most-negative, HI = 0.
- `start` while `busy`=1 is ignored; it is neither queued nor an error.
- `flush`: the next state is IDLE from any state. HI/LO keep their prior values and no `done` is produced. `flush` beats `start` in the same cycle.
- `wr_hi`/`wr_lo`:
  - The write applies at the edge in any state.
  - If busy, the in-flight operation is cancelled exactly as on flush.
  - A direct write beats a FIX-state result write to the same register. The other register still takes the result only if its own write is not asserted; `done` still pulses.
  - In IDLE, `start` in the same cycle is ignored.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0, datapath registers 0.
- Cycle numbering: cycle 0 has `start`=1 with `busy`=0.
  - Cycles 1..W: RUN, `busy`=1.
  - Cycle W+1: FIX, `busy`=1.
  - Cycle W+2: `busy`=0, `done`=1, `hi`/`lo` updated (cycle 34 for W=32).
- The earliest next `start` is in cycle W+2, which gives back-to-back throughput of one operation per W+2 cycles.
- `hi`/`lo` change only:
  - at reset;
  - at a FIX→IDLE edge;
  - on `wr_hi`/`wr_lo`.
- `reset` mid-operation returns to reset values at the next edge. No `done` is produced.
- `flush` in cycle k (RUN or FIX): `busy`=0 in cycle k+1 and `start` is accepted in cycle k+1.
- Outputs are registered; there is no combinational path from inputs to `busy`, `done`, `hi` or `lo`.

## Test plan
- W=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF → `done` in cycle 34, hi=0xFFFFFFFE, lo=0x00000001. `busy` is high in cycles 1–33 exactly.
- MULT a=0xFFFFFFFD (−3) b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Back-to-back MULT 0×0x7FFFFFFF started in cycle 34 → hi=lo=0 in cycle 68.
- DIV a=0xFFFFFFF9 (−7) b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=100 b=0 → lo=0xFFFFFFFF, hi=0x00000064, still in cycle 34.
- Preload hi=0x11, lo=0x22, start MULTU, then:
  - `flush` in cycle 10 → `busy`=0 in cycle 11, no `done`, hi/lo unchanged;
  - `start` in cycle 11 → `done` in cycle 45;
  - `reset` mid-operation → all outputs 0 next cycle, no `done`.
- MULTU 3×4 with `wr_hi` (wdata=0xAA) in cycle 5 → cancelled: hi=0xAA, lo unchanged, no `done`. A `start` in cycle 20 of a running operation is ignored.
